// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, mux select codes
// and the per-state control word used by the controller.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_SEXT  = 2'b10;
    localparam logic [1:0] SRCB_SHIFT = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    function automatic logic is_known_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: is_known_op = 1'b1;
            default:                                       is_known_op = 1'b0;
        endcase
    endfunction

    // Unconditional Moore control word of each state; wait/zero/reset gating is applied at the top.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.pc_en     = 1'b1;
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_source = PC_SRC_ALU;
                c.alu_op    = ALUOP_ADD;
            end
            S_DECODE: c.alu_src_b = SRCB_SHIFT;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_SEXT;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_REXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.alu_op    = ALUOP_SUB;
                c.pc_source = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_source = PC_SRC_JUMP;
                c.pc_en     = 1'b1;
            end
            S_IEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_SEXT;
            end
            S_IWB: c.reg_write = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: state register plus a control word registered alongside it,
// so every output is a state decode with no added latency.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_enable,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [3:0] state,
    output logic       illegal_op
);

    state_t cur_state;
    state_t next_state;
    ctrl_t  ctrl_q;
    logic   illegal_q;
    logic   ready_ok;

    assign ready_ok = !MEM_WAIT_EN || mem_ready;

    always_comb begin
        next_state = S_FETCH;
        case (cur_state)
            S_FETCH:  next_state = ready_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_REXEC;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_IEXEC;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = ready_ok ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next_state = ready_ok ? S_FETCH : S_MEMWR;
            S_REXEC:  next_state = S_RWB;
            S_IEXEC:  next_state = S_IWB;
            default:  next_state = S_FETCH;
        endcase
    end

    // The control word is computed from the next state so it lines up with cur_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_FETCH;
            ctrl_q    <= state_ctrl(S_FETCH);
            illegal_q <= 1'b0;
        end else begin
            cur_state <= next_state;
            ctrl_q    <= state_ctrl(next_state);
            if (cur_state == S_DECODE && !is_known_op(opcode)) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // pc_enable follows zero in BEQ and, like ir_write, waits for memory in FETCH.
    assign pc_enable  = !rst && ((ctrl_q.pc_en && (cur_state != S_FETCH || ready_ok))
                                 || (cur_state == S_BEQ && zero));
    assign ir_write   = !rst && ctrl_q.ir_write && ready_ok;
    assign mem_write  = !rst && ctrl_q.mem_write;
    assign reg_write  = !rst && ctrl_q.reg_write;
    assign pc_source  = ctrl_q.pc_source;
    assign iord       = ctrl_q.iord;
    assign mem_read   = ctrl_q.mem_read;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign state      = cur_state;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level model feeds a scoreboard queue, and a
// negedge monitor compares one expected control word per cycle against the selected DUT.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_enable;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
    } obs_t;

    typedef struct {
        obs_t v;
        bit   sel;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst0, rst1;
    logic [5:0] opcode;
    logic       zero, mem_ready;

    logic       pe0, iord0, mr0, mw0, irw0, asa0, rd0, m2r0, rw0, ill0;
    logic [1:0] ps0, asb0, aop0;
    logic [3:0] st0;
    logic       pe1, iord1, mr1, mw1, irw1, asa1, rd1, m2r1, rw1, ill1;
    logic [1:0] ps1, asb1, aop1;
    logic [3:0] st1;

    obs_t obs0, obs1;
    assign obs0 = {st0, pe0, ps0, iord0, mr0, mw0, irw0, asa0, asb0, aop0, rd0, m2r0, rw0, ill0};
    assign obs1 = {st1, pe1, ps1, iord1, mr1, mw1, irw1, asa1, asb1, aop1, rd1, m2r1, rw1, ill1};

    always #5 clk = ~clk;

    multicycle_control #(.MEM_WAIT_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_enable(pe0), .pc_source(ps0), .iord(iord0), .mem_read(mr0), .mem_write(mw0),
        .ir_write(irw0), .alu_src_a(asa0), .alu_src_b(asb0), .alu_op(aop0), .reg_dst(rd0),
        .mem_to_reg(m2r0), .reg_write(rw0), .state(st0), .illegal_op(ill0)
    );

    multicycle_control #(.MEM_WAIT_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_enable(pe1), .pc_source(ps1), .iord(iord1), .mem_read(mr1), .mem_write(mw1),
        .ir_write(irw1), .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1), .reg_dst(rd1),
        .mem_to_reg(m2r1), .reg_write(rw1), .state(st1), .illegal_op(ill1)
    );

    sb_t        sb[$];
    logic [3:0] pend[$];
    int         checks = 0;
    int         errors = 0;
    bit         sel = 1'b0;
    bit         m_illegal = 1'b0;
    logic [5:0] cur_op = 6'd0;
    int         force_low = 0;
    int         low_streak = 0;
    int         zero_mode = -1;

    function automatic bit opLegal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    // Control values each state must present, straight from the state tables.
    function automatic obs_t expectFor(input logic [3:0] st, input bit r, input bit z,
                                       input bit rdy, input bit w, input bit ill);
        obs_t e;
        bit   ok;
        e = '0;
        e.st = st;
        e.illegal_op = ill;
        ok = !w || rdy;
        case (st)
            4'd0:  begin e.mem_read = 1; e.ir_write = ok; e.pc_enable = ok; e.alu_src_b = 2'b01; end
            4'd1:  e.alu_src_b = 2'b11;
            4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4'd3:  begin e.mem_read = 1; e.iord = 1; end
            4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            4'd5:  begin e.mem_write = 1; e.iord = 1; end
            4'd6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            4'd7:  begin e.reg_write = 1; e.reg_dst = 1; end
            4'd8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 2'b01; e.pc_enable = z; end
            4'd9:  begin e.pc_source = 2'b10; e.pc_enable = 1; end
            4'd10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4'd11: e.reg_write = 1;
            default: ;
        endcase
        if (r) begin
            e.pc_enable = 0;
            e.ir_write = 0;
            e.mem_write = 0;
            e.reg_write = 0;
        end
        return e;
    endfunction

    task automatic loadSeq(input logic [5:0] op);
        pend.delete();
        pend.push_back(4'd0);
        pend.push_back(4'd1);
        case (op)
            6'b100011: begin pend.push_back(4'd2); pend.push_back(4'd3); pend.push_back(4'd4); end
            6'b101011: begin pend.push_back(4'd2); pend.push_back(4'd5); end
            6'b000000: begin pend.push_back(4'd6); pend.push_back(4'd7); end
            6'b001000: begin pend.push_back(4'd10); pend.push_back(4'd11); end
            6'b000100: pend.push_back(4'd8);
            6'b000010: pend.push_back(4'd9);
            default: ;
        endcase
    endtask

    // One clock of stimulus: drive inputs, queue the expected outputs, advance the model.
    task automatic applyStimulus(input bit r, input bit chk);
        logic [3:0] cur;
        bit         rdy, z, hold;
        sb_t        item;
        @(posedge clk);
        #1;
        z = (zero_mode < 0) ? bit'($urandom_range(0, 1)) : bit'(zero_mode);
        if (force_low > 0) begin
            rdy = 0;
            force_low--;
        end else if (low_streak >= 3) begin
            rdy = 1;
        end else begin
            rdy = ($urandom_range(0, 2) != 0);
        end
        low_streak = rdy ? 0 : low_streak + 1;
        opcode = cur_op;
        zero = z;
        mem_ready = rdy;
        rst0 = sel ? 1'b1 : r;
        rst1 = sel ? r : 1'b1;
        cur = (pend.size() > 0) ? pend[0] : 4'd0;
        if (chk) begin
            item.v = expectFor(cur, r, z, rdy, sel, m_illegal);
            item.sel = sel;
            sb.push_back(item);
        end
        if (r) begin
            pend.delete();
            m_illegal = 0;
        end else begin
            hold = sel && !rdy && (cur == 4'd0 || cur == 4'd3 || cur == 4'd5);
            if (!hold && pend.size() > 0) begin
                if (cur == 4'd1 && !opLegal(cur_op)) m_illegal = 1;
                void'(pend.pop_front());
            end
        end
    endtask

    task automatic runInstr(input logic [5:0] op, input int abort_at, input int fetch_low);
        int n;
        n = 0;
        cur_op = op;
        loadSeq(op);
        force_low = fetch_low;
        while (pend.size() > 0) begin
            if (n == abort_at) begin
                applyStimulus(1'b1, 1'b1);
                break;
            end
            applyStimulus(1'b0, 1'b1);
            n++;
        end
        force_low = 0;
    endtask

    task automatic checkOutput(input sb_t item);
        obs_t got;
        got = item.sel ? obs1 : obs0;
        checks++;
        if (got !== item.v) begin
            errors++;
            $display("[TB] FAIL ctrl dut%0d t=%0t: state got %0d exp %0d, word got %h exp %h",
                     item.sel, $time, got.st, item.v.st, got, item.v);
        end
        checks++;
        if (got.mem_read === 1'b1 && got.mem_write === 1'b1) begin
            errors++;
            $display("[TB] FAIL mem_excl dut%0d t=%0t: mem_read=%b mem_write=%b, must not both be 1",
                     item.sel, $time, got.mem_read, got.mem_write);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    task automatic randomRun(input int count, input int max_low);
        logic [5:0] ops [7];
        logic [5:0] op;
        int         abort;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
        for (int i = 0; i < count; i++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 6'b111111) op = 6'($urandom_range(48, 62));
            abort = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            runInstr(op, abort, int'($urandom_range(0, max_low)));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: stimulus did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst0 = 1; rst1 = 1; opcode = '0; zero = 0; mem_ready = 1;
        sel = 0;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        runInstr(OP_LW, 3, 0);
        runInstr(OP_LW, -1, 0);
        zero_mode = 1; runInstr(OP_BEQ, -1, 0);
        zero_mode = 0; runInstr(OP_BEQ, -1, 0);
        zero_mode = -1;
        runInstr(6'b111111, -1, 0);
        runInstr(OP_SW, -1, 0);
        runInstr(OP_RTYPE, -1, 0);
        runInstr(OP_ADDI, -1, 0);
        runInstr(OP_J, -1, 0);
        applyStimulus(1'b1, 1'b1);
        randomRun(40, 0);

        sel = 1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        runInstr(OP_LW, -1, 3);
        runInstr(OP_SW, -1, 2);
        runInstr(OP_LW, 4, 0);
        runInstr(6'b111111, -1, 1);
        runInstr(OP_J, -1, 0);
        applyStimulus(1'b1, 1'b1);
        randomRun(40, 2);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left in scoreboard, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one parameter: MEM_WAIT_EN, default 0; when 1, memory states wait for mem_ready.
REQ-002 The block SHALL have these ports, one clock, with reset synchronous and active-high:
- clk, input, 1 bit: rising-edge clock.
- rst, input, 1 bit: synchronous active-high reset.
- opcode, input, 6 bits: instr[31:26] from the instruction register.
- zero, input, 1 bit: ALU zero flag.
- mem_ready, input, 1 bit: memory access complete.
- pc_enable, output, 1 bit: enable to the program counter.
- pc_source, output, 2 bits: next-PC select. 00 is ALU result, 01 is ALUOut, 10 is jump target.
- iord, output, 1 bit: memory address select. 0 is PC, 1 is ALUOut.
- mem_read, output, 1 bit.
- mem_write, output, 1 bit.
- ir_write, output, 1 bit.
- alu_src_a, output, 1 bit: 0 is PC, 1 is regA.
- alu_src_b, output, 2 bits: 00 is regB, 01 is constant 4, 10 is sign-extended immediate, 11 is shifted immediate.
- alu_op, output, 2 bits: 00 is add, 01 is sub, 10 is funct-decoded.
- reg_dst, output, 1 bit.
- mem_to_reg, output, 1 bit.
- reg_write, output, 1 bit.
- state, output, 4 bits: current state encoding, for debug.
- illegal_op, output, 1 bit: sticky flag for an undefined opcode.

Function
REQ-003 The FSM SHALL be Moore-style, except pc_enable; all outputs SHALL be registered state decode with no extra latency.
REQ-004 The states and their encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BEQ=8, JUMP=9, IEXEC=10, IWB=11.
REQ-005 The opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-006 FETCH SHALL assert mem_read and ir_write with iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_enable=1, and then go to DECODE.
REQ-007 DECODE SHALL set alu_src_a=0, alu_src_b=11, alu_op=00 and branch on opcode:
- lw or sw: MEMADR.
- R-type: REXEC.
- beq: BEQ.
- j: JUMP.
- addi: IEXEC.
- any other opcode: FETCH, setting illegal_op.
REQ-008 MEMADR SHALL set alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEMRD for lw or MEMWR for sw.
REQ-009 MEMRD SHALL assert mem_read with iord=1, then go to MEMWB; MEMWB SHALL assert reg_write with mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-010 MEMWR SHALL assert mem_write with iord=1, then go to FETCH.
REQ-011 When MEM_WAIT_EN=1, FETCH, MEMRD and MEMWR SHALL hold while mem_ready=0, holding ir_write and pc_enable low during the wait and asserting them only in the mem_ready=1 cycle.
REQ-012 When MEM_WAIT_EN=0, mem_ready SHALL be ignored and every state SHALL last exactly one cycle.
REQ-013 REXEC SHALL set alu_src_a=1, alu_src_b=00, alu_op=10, then go to RWB; RWB SHALL assert reg_write with reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-014 BEQ SHALL set alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, with pc_enable equal to zero (combinational), then go to FETCH.
REQ-015 JUMP SHALL set pc_source=10 and pc_enable=1, then go to FETCH.
REQ-016 IEXEC SHALL set alu_src_a=1, alu_src_b=10, alu_op=00, then go to IWB; IWB SHALL assert reg_write with reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-017 The cycle counts with MEM_WAIT_EN=0 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-018 In every state, outputs not listed for that state SHALL be 0.
REQ-019 Unused state encodings 12-15 SHALL go to FETCH on the next clock.
REQ-020 mem_read and mem_write SHALL never be asserted in the same cycle.

Reset
REQ-021 With rst=1 at a rising clk, state SHALL become FETCH and illegal_op SHALL become 0, regardless of the current state, including mid-instruction and during a memory wait.
REQ-022 While rst=1, pc_enable, ir_write, mem_write and reg_write SHALL be forced to 0.
REQ-023 The first FETCH outputs SHALL appear in the first cycle after rst deasserts.

Structure
REQ-024 A shared package SHALL hold the state encodings, opcode constants, and the pc_source, alu_src_b and alu_op codes, for use by the datapath and the testbench.
REQ-025 The block SHALL be a single module with a state register and next-state/output decode; there SHALL be no sub-module.

Verification
REQ-026 Reset: assert rst during MEMRD, then release it; state SHALL be 0 and outputs SHALL show FETCH values one cycle after release.
REQ-027 lw: opcode=100011, MEM_WAIT_EN=0; the state sequence SHALL be 0,1,2,3,4,0, with reg_write=1 only in state 4.
REQ-028 beq: opcode=000100 with zero=1 in BEQ SHALL give pc_enable=1 and pc_source=01; with zero=0, pc_enable SHALL be 0.
REQ-029 Memory wait: MEM_WAIT_EN=1 with mem_ready low for 3 cycles in FETCH; FETCH SHALL persist 4 cycles, with ir_write and pc_enable high only in the 4th.
REQ-030 Illegal opcode: opcode=111111 SHALL give DECODE then FETCH with illegal_op=1, sticky until rst.
REQ-031 Per-opcode cycle counts: run sw, R-type, addi and j back-to-back; the counts SHALL be 4, 4, 4, 3, and mem_read and mem_write SHALL never both be 1.
